key_lut_writer: RTL and testbench
=================================

# key_lut_writer

Runtime writer for the packed key/data lookup bus consumed by the `MuxKey`/`MuxKeyWithDefault` selectors. It owns `NR_KEY` registered key/data entries and accepts insert, update and delete requests over a valid/ready port. It keeps keys unique among valid entries and drives the packed `lut` bus plus a per-entry valid mask. It sits between control logic (CSR/decoder programming paths in the npc core) and any selector whose table must change at run time.

## Interface
- `NR_KEY`, 4, number of entries (≥2)
- `KEY_LEN`, 2, key width in bits
- `DATA_LEN`, 1, data width in bits
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: request valid.
- `wr_ready` out 1: request accepted when `wr_valid && wr_ready` at a rising edge.
- `wr_del` in 1: 1 = delete `wr_key`; 0 = insert/update.
- `wr_key` in `KEY_LEN`: request key.
- `wr_data` in `DATA_LEN`: request data (ignored on delete).
- `clr` in 1: start clear sweep (sampled only in IDLE).
- `wr_done` out 1: one-cycle pulse when a request completes.
- `wr_hit` out 1: valid with `wr_done`; the key existed before the request.
- `wr_err` out 1: valid with `wr_done`; the insert was dropped (table full), or a delete missed.
- `busy` out 1: high in any state other than IDLE.
- `count` out `$clog2(NR_KEY+1)`: number of valid entries.
- `valid_mask` out `NR_KEY`: bit n = entry n valid.
- `lut` out `NR_KEY*(KEY_LEN+DATA_LEN)`: entry n at bits `[(KEY_LEN+DATA_LEN)*(n+1)-1 : (KEY_LEN+DATA_LEN)*n]`, packed as `{key, data}` with key in the upper bits.

## Operation
- States:
  - IDLE: `wr_ready`=1.
  - MATCH: one cycle. Compares the latched key against all valid entries in parallel.
  - CLEAR: sweeps one entry per cycle.
- IDLE transitions:
  - `clr`=1 → CLEAR, index 0. `clr` has priority over `wr_valid` in the same cycle; `wr_ready` drops and the write is not accepted.
  - Handshake → latch `wr_del`/`wr_key`/`wr_data`, go to MATCH.
- MATCH, insert:
  - Hit → overwrite data of the matching entry; `wr_hit`=1.
  - Miss and not full → write lowest-index free entry, set its valid bit, `count`+1.
  - Miss and full → table unchanged; `wr_err`=1.
- MATCH, delete:
  - Hit → zero the entry's key and data, clear its valid bit, `count`−1; `wr_hit`=1.
  - Miss → `wr_err`=1.
- MATCH always returns to IDLE and pulses `wr_done`.
- CLEAR: zeroes entry `idx` and its valid bit each cycle. After `idx`=NR_KEY-1, sets `count`=0 and returns to IDLE. No `wr_done` for clear.
- Invalid entries always present all-zero pairs on `lut`. Data then ORs as 0 in `MuxKey`. A consumer that needs a hit must qualify it with `valid_mask`.
- Invariant: no two valid entries hold the same key. `count` equals popcount(`valid_mask`).

## Timing
- Reset (async, while `rst_n`=0):
  - all entries 0, `valid_mask`=0, `count`=0, state IDLE.
  - `wr_ready`, `wr_done`, `wr_hit`, `wr_err`, `busy` all 0.
  - `wr_ready` rises at the first rising edge after `rst_n` deasserts.
- Request accepted at edge T → MATCH during cycle T..T+1 → at edge T+1, `lut`/`valid_mask`/`count` update and `wr_done` rises for one cycle → `wr_ready`=1 again in that same cycle.
- Throughput: one request per 2 cycles.
- Clear starting at edge T: `busy`=1 for NR_KEY cycles; `wr_ready`=1 from edge T+NR_KEY.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-MATCH or mid-CLEAR: immediate return to reset values. The partial operation is discarded.

## Configuration
- `KEY_LUT_WRITER_OVERWRITE_EN` defined: an insert that misses on a full table overwrites a victim entry and completes with `wr_err`=0, `wr_hit`=0.
  - The victim is chosen by a round-robin pointer (reset 0). The pointer advances by 1 modulo NR_KEY on each victim overwrite.
  - `count` is unchanged.
- Undefined: full-table miss is dropped with `wr_err`=1; no pointer is implemented.

## Test plan
(NR_KEY=4, KEY_LEN=2, DATA_LEN=1)
- Reset, then insert key 2 data 1 → `wr_done` one cycle after accept; `wr_hit`=0; `valid_mask`=4'b0001; `lut[2:0]`=3'b101; `count`=1.
- Insert key 2 data 0 after the above → `wr_hit`=1; `lut[2:0]`=3'b100; `count` stays 1.
- Insert keys 0, 1, 3 data 1, then key 2 → full table.
  - Then insert key 2 data 1 → `wr_hit`=1.
  - Then insert a new key after deleting key 0, then re-adding key 0 → table full again.
  - Without the macro: a fifth unique insert (`count`=4 remains) gives `wr_err`=1, `lut` unchanged.
  - With the macro: entry 0 is replaced, `wr_err`=0.
- Delete key 1 → `wr_hit`=1, entry zeroed, its valid bit cleared, `count`−1. Delete key 1 again → `wr_err`=1.
- Assert `clr` together with `wr_valid` in IDLE → write not accepted; `busy`=1 for 4 cycles; then `valid_mask`=0, `count`=0, `lut`=0, `wr_ready`=1.
- Drop `rst_n` during MATCH → all outputs are zero immediately; the first request after reset completes normally.

Source files
------------

// File: rtl/key_lut_writer.sv
// Runtime writer for a packed {key,data} lookup bus: a request accepted at edge T completes at T+1, and wr_ready is low while busy.
// Optional KEY_LUT_WRITER_OVERWRITE_EN: a miss on a full table replaces a round-robin victim instead of being dropped.
module key_lut_writer #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic                                    wr_del,
  input  logic [KEY_LEN-1:0]                      wr_key,
  input  logic [DATA_LEN-1:0]                     wr_data,
  input  logic                                    clr,
  output logic                                    wr_done,
  output logic                                    wr_hit,
  output logic                                    wr_err,
  output logic                                    busy,
  output logic [$clog2(NR_KEY+1)-1:0]             count,
  output logic [NR_KEY-1:0]                       valid_mask,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut
);

  localparam int EW = KEY_LEN + DATA_LEN;
  localparam int CW = $clog2(NR_KEY + 1);
  localparam int IW = $clog2(NR_KEY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NR_KEY - 1);

  typedef enum logic [1:0] {IDLE, MATCH, CLEAR} state_e;

  state_e                state_q;
  logic [KEY_LEN-1:0]    key_q  [NR_KEY];
  logic [DATA_LEN-1:0]   data_q [NR_KEY];
  logic [NR_KEY-1:0]     valid_q;
  logic [CW-1:0]         count_q;
  logic [IW-1:0]         idx_q;
  logic                  lat_del_q;
  logic [KEY_LEN-1:0]    lat_key_q;
  logic [DATA_LEN-1:0]   lat_data_q;
  logic                  wr_ready_q;
  logic                  wr_done_q;
  logic                  wr_hit_q;
  logic                  wr_err_q;
  logic                  busy_q;
`ifdef KEY_LUT_WRITER_OVERWRITE_EN
  logic [IW-1:0]         rr_ptr_q;
`endif

  // Parallel key compare and lowest-index free-slot search; descending loop lets the lowest index win.
  logic                  hit_any;
  logic [IW-1:0]         hit_idx;
  logic                  free_any;
  logic [IW-1:0]         free_idx;

  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int n = NR_KEY - 1; n >= 0; n--) begin
      if (valid_q[n] && (key_q[n] == lat_key_q)) begin
        hit_any = 1'b1;
        hit_idx = IW'(n);
      end
      if (!valid_q[n]) begin
        free_any = 1'b1;
        free_idx = IW'(n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      lat_del_q  <= 1'b0;
      lat_key_q  <= '0;
      lat_data_q <= '0;
      wr_ready_q <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_hit_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef KEY_LUT_WRITER_OVERWRITE_EN
      rr_ptr_q   <= '0;
`endif
      for (int n = 0; n < NR_KEY; n++) begin
        key_q[n]  <= '0;
        data_q[n] <= '0;
      end
    end else begin
      wr_done_q <= 1'b0;
      wr_hit_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (wr_valid && wr_ready_q) begin
            state_q    <= MATCH;
            lat_del_q  <= wr_del;
            lat_key_q  <= wr_key;
            lat_data_q <= wr_data;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            wr_ready_q <= 1'b1;
          end
        end

        MATCH: begin
          state_q    <= IDLE;
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          wr_done_q  <= 1'b1;
          if (lat_del_q) begin
            if (hit_any) begin
              key_q[hit_idx]   <= '0;
              data_q[hit_idx]  <= '0;
              valid_q[hit_idx] <= 1'b0;
              count_q          <= count_q - CNT_ONE;
              wr_hit_q         <= 1'b1;
            end else begin
              wr_err_q <= 1'b1;
            end
          end else if (hit_any) begin
            data_q[hit_idx] <= lat_data_q;
            wr_hit_q        <= 1'b1;
          end else if (free_any) begin
            key_q[free_idx]   <= lat_key_q;
            data_q[free_idx]  <= lat_data_q;
            valid_q[free_idx] <= 1'b1;
            count_q           <= count_q + CNT_ONE;
          end else begin
`ifdef KEY_LUT_WRITER_OVERWRITE_EN
            // Victim stays valid, so count is unchanged; the missed key cannot duplicate another.
            key_q[rr_ptr_q]  <= lat_key_q;
            data_q[rr_ptr_q] <= lat_data_q;
            rr_ptr_q         <= (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + IW'(1);
`else
            wr_err_q <= 1'b1;
`endif
          end
        end

        CLEAR: begin
          key_q[idx_q]   <= '0;
          data_q[idx_q]  <= '0;
          valid_q[idx_q] <= 1'b0;
          if (idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Invalid entries are kept zeroed, so the bus needs no masking here.
  for (genvar n = 0; n < NR_KEY; n++) begin : g_lut
    assign lut[EW*n +: EW] = {key_q[n], data_q[n]};
  end

  assign wr_ready   = wr_ready_q;
  assign wr_done    = wr_done_q;
  assign wr_hit     = wr_hit_q;
  assign wr_err     = wr_err_q;
  assign busy       = busy_q;
  assign count      = count_q;
  assign valid_mask = valid_q;

endmodule

// File: tb/tb_key_lut_writer.sv
// Self-checking bench for key_lut_writer: directed steps plus randomized requests against a table model.
module tb_key_lut_writer;

  // KEY_LEN=3 gives more keys than entries so a full-table miss can be exercised.
  localparam int NR = 4;
  localparam int KL = 3;
  localparam int DL = 1;
  localparam int EW = KL + DL;
  localparam int CW = $clog2(NR + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_del = 1'b0;
  logic [KL-1:0]     wr_key = '0;
  logic [DL-1:0]     wr_data = '0;
  logic              clr = 1'b0;
  logic              wr_ready, wr_done, wr_hit, wr_err, busy;
  logic [CW-1:0]     count;
  logic [NR-1:0]     valid_mask;
  logic [NR*EW-1:0]  lut;

  int tests = 0;
  int fails = 0;

  logic [KL-1:0] mk [NR];
  logic [DL-1:0] md [NR];
  bit            mv [NR];
  int            rr;
  logic          last_hit, last_err;

  key_lut_writer #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_del(wr_del), .wr_key(wr_key), .wr_data(wr_data), .clr(clr),
    .wr_done(wr_done), .wr_hit(wr_hit), .wr_err(wr_err), .busy(busy),
    .count(count), .valid_mask(valid_mask), .lut(lut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      $error("%s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NR; n++) begin
      mk[n] = '0; md[n] = '0; mv[n] = 0;
    end
    rr = 0;
  endtask

  function automatic logic [NR*EW-1:0] exp_lut();
    logic [NR*EW-1:0] v = '0;
    for (int n = 0; n < NR; n++) v[EW*n +: EW] = {mk[n], md[n]};
    return v;
  endfunction

  function automatic logic [NR-1:0] exp_mask();
    logic [NR-1:0] v = '0;
    for (int n = 0; n < NR; n++) v[n] = mv[n];
    return v;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int n = 0; n < NR; n++) if (mv[n]) c++;
    return c;
  endfunction

  task automatic check_table(input string tag);
    check({tag, "_lut"},   lut,        exp_lut());
    check({tag, "_mask"},  valid_mask, exp_mask());
    check({tag, "_count"}, count,      exp_count());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, wr_ready, 0);
    check({tag, "_done"},  wr_done, 0);
    check({tag, "_hit"},   wr_hit, 0);
    check({tag, "_err"},   wr_err, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_mask"},  valid_mask, 0);
    check({tag, "_lut"},   lut, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 16 && !wr_ready; i++) @(negedge clk);
    check("wait_ready", wr_ready, 1);
  endtask

  // Applies a request, updates the model from the table rules, and checks the completion cycle.
  task automatic do_req(input bit del, input logic [KL-1:0] key, input logic [DL-1:0] data);
    int    at = -1;
    int    fr = -1;
    bit    eh = 0;
    bit    ee = 0;
    @(negedge clk);
    check("done_pulse_end", wr_done, 0);
    wait_ready();
    for (int n = 0; n < NR; n++) if (mv[n] && mk[n] == key) at = n;
    if (del) begin
      if (at >= 0) begin
        eh = 1; mv[at] = 0; mk[at] = '0; md[at] = '0;
      end else ee = 1;
    end else if (at >= 0) begin
      eh = 1; md[at] = data;
    end else begin
      for (int n = NR - 1; n >= 0; n--) if (!mv[n]) fr = n;
      if (fr >= 0) begin
        mv[fr] = 1; mk[fr] = key; md[fr] = data;
      end else begin
`ifdef KEY_LUT_WRITER_OVERWRITE_EN
        mk[rr] = key; md[rr] = data; rr = (rr + 1) % NR;
`else
        ee = 1;
`endif
      end
    end
    wr_valid = 1'b1; wr_del = del; wr_key = key; wr_data = data;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    check("match_busy", busy, 1);
    check("match_ready", wr_ready, 0);
    check("match_done", wr_done, 0);
    @(negedge clk);
    last_hit = wr_hit;
    last_err = wr_err;
    check("req_done", wr_done, 1);
    check("req_hit", wr_hit, eh);
    check("req_err", wr_err, ee);
    check("req_ready", wr_ready, 1);
    check("req_busy", busy, 0);
    check_table("req");
  endtask

  task automatic do_clear(input bit with_valid);
    @(negedge clk);
    wait_ready();
    clr = 1'b1;
    wr_valid = with_valid;
    wr_del = 1'b0;
    wr_key = KL'($urandom_range(0, (1 << KL) - 1));
    wr_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      check("clr_busy", busy, 1);
      check("clr_ready", wr_ready, 0);
      check("clr_done", wr_done, 0);
      @(negedge clk);
    end
    model_reset();
    check("clr_end_busy", busy, 0);
    check("clr_end_ready", wr_ready, 1);
    check_table("clr_end");
  endtask

  initial begin
    model_reset();
    last_hit = 0;
    last_err = 0;

    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", wr_ready, 1);

    do_req(0, 3'd2, 1'b1);
    check("first_lut_entry0", lut[EW-1:0], 4'b0101);
    check("first_mask", valid_mask, 4'b0001);
    check("first_count", count, 1);
    do_req(0, 3'd2, 1'b0);
    check("update_hit", last_hit, 1);
    check("update_lut_entry0", lut[EW-1:0], 4'b0100);
    check("update_count", count, 1);

    do_req(0, 3'd0, 1'b1);
    do_req(0, 3'd1, 1'b1);
    do_req(0, 3'd3, 1'b1);
    check("full_count", count, 4);
    do_req(0, 3'd2, 1'b1);
    check("full_update_hit", last_hit, 1);

    do_req(1, 3'd0, 1'b0);
    do_req(0, 3'd6, 1'b1);
    check("refill_count", count, 4);
    do_req(0, 3'd0, 1'b1);
`ifdef KEY_LUT_WRITER_OVERWRITE_EN
    check("overflow_err", last_err, 0);
    check("overflow_victim0", lut[EW-1:0], 4'b0001);
`else
    check("overflow_err", last_err, 1);
    check("overflow_count", count, 4);
`endif

    do_req(1, 3'd1, 1'b0);
    check("delete_hit", last_hit, 1);
    do_req(1, 3'd1, 1'b0);
    check("delete_miss_err", last_err, 1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) do_clear(0);
      else do_req($urandom_range(0, 9) < 3, KL'($urandom_range(0, (1 << KL) - 1)),
                  DL'($urandom_range(0, 1)));
    end

    do_req(0, 3'd4, 1'b1);
    do_clear(1);

    do_req(0, 3'd5, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1; wr_del = 1'b0; wr_key = 3'd7; wr_data = 1'b1;
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_match");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 3'd5, 1'b1);
    check("post_reset_mask", valid_mask, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
